// File: rtl/disp_conf_sequencer.sv
// disp_conf_sequencer
//   Front-end controller for the disparity filtering pixel processor. It merges
//   the disparity/confidence sample stream with the mask-pixel column stream.
//   Each sample is replayed across dec_factor consecutive column beats. The
//   block tracks row and column over one frame. Because the processor input
//   has no ready, issue is gated by credits held against the processor output
//   FIFO.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   start                     pulse; arms one frame (ignored unless idle)
//   dc_disp/dc_conf/dc_valid  disparity/confidence sample stream, dc_ready out
//   mask_col/mask_valid       mask pixel column stream, mask_ready out
//   pp_pixels/pp_disp/pp_conf/pp_valid  registered beat to the processor
//   pp_pop                    processor output popped; returns one credit
//   x_count/y_count           current sample column / row
//   busy                      frame in progress (run or drain)
//   frame_done                one-cycle pulse when the frame has fully drained
//   credit_err                sticky; pop seen with all credits already home
module disp_conf_sequencer #(
  parameter int disp_bits  = 5,
  parameter int dec_factor = 2,
  parameter int out_width  = 320,
  parameter int out_height = 240,
  parameter int fifo_depth = 128
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [disp_bits-1:0]          dc_disp,
  input  logic [7:0]                    dc_conf,
  input  logic                          dc_valid,
  output logic                          dc_ready,
  input  logic [dec_factor-1:0]         mask_col,
  input  logic                          mask_valid,
  output logic                          mask_ready,
  output logic [dec_factor-1:0]         pp_pixels,
  output logic [disp_bits-1:0]          pp_disp,
  output logic [7:0]                    pp_conf,
  output logic                          pp_valid,
  input  logic                          pp_pop,
  output logic [$clog2(out_width)-1:0]  x_count,
  output logic [$clog2(out_height)-1:0] y_count,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          credit_err
);

  localparam int XW = $clog2(out_width);
  localparam int YW = $clog2(out_height);
  localparam int BW = $clog2(dec_factor);
  localparam int CW = $clog2(fifo_depth + 1);

  localparam logic [XW-1:0] X_LAST    = XW'(out_width - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(out_height - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(dec_factor - 1);
  localparam logic [CW-1:0] CRED_FULL = CW'(fifo_depth);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_next;
  logic [BW-1:0] beat_cnt;
  logic [CW-1:0] credits, credits_next;
  logic          issue, take, last_beat, frame_last;
  logic          credit_ovf, frame_done_next;

  // Beat 0 needs a fresh sample and a free FIFO slot; later beats of the same
  // sample only need a mask column, since their FIFO slot is already reserved.
  always_comb begin
    issue = 1'b0;
    if (state == RUN)
      issue = mask_valid && (beat_cnt != '0 || (dc_valid && credits != '0));
  end

  assign take       = issue && (beat_cnt == '0);
  assign last_beat  = issue && (beat_cnt == BEAT_LAST);
  assign frame_last = last_beat && (x_count == X_LAST) && (y_count == Y_LAST);
  assign credit_ovf = pp_pop && (credits == CRED_FULL);

  assign mask_ready = issue;
  assign dc_ready   = take;
  assign busy       = (state != IDLE);

  always_comb begin
    credits_next = credits;
    unique case ({take, pp_pop})
      2'b10:   credits_next = credits - 1'b1;
      // A pop with every credit already home is an error; hold the count.
      2'b01:   if (credits != CRED_FULL) credits_next = credits + 1'b1;
      default: credits_next = credits;
    endcase
  end

  always_comb begin
    state_next      = state;
    frame_done_next = 1'b0;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (frame_last) state_next = DRAIN;
      DRAIN: begin
        if (credits == CRED_FULL) begin
          state_next      = IDLE;
          frame_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      credits    <= CRED_FULL;
      credit_err <= 1'b0;
      beat_cnt   <= '0;
      x_count    <= '0;
      y_count    <= '0;
      pp_pixels  <= '0;
      pp_disp    <= '0;
      pp_conf    <= '0;
      pp_valid   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      credits    <= credits_next;
      frame_done <= frame_done_next;
      pp_valid   <= issue;
      if (credit_ovf) credit_err <= 1'b1;
      if (issue) begin
        pp_pixels <= mask_col;
        beat_cnt  <= last_beat ? '0 : beat_cnt + 1'b1;
      end
      // Sample fields hold across stalls and the remaining beats of a sample.
      if (take) begin
        pp_disp <= dc_disp;
        pp_conf <= dc_conf;
      end
      if (last_beat) begin
        if (x_count == X_LAST) begin
          x_count <= '0;
          y_count <= (y_count == Y_LAST) ? '0 : y_count + 1'b1;
        end else begin
          x_count <= x_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_disp_conf_sequencer.sv
// tb_disp_conf_sequencer
//   Directed sequence of frames with randomized data, valids and pops, checked
//   every cycle against a transaction-level model: a running beat total gives
//   beat/column/row by division, and credits follow min(c - take + pop, depth).
module tb_disp_conf_sequencer;

  localparam int DB    = 5;
  localparam int D     = 2;
  localparam int W     = 4;
  localparam int H     = 3;
  localparam int DEPTH = 8;
  localparam int TOTAL = D * W * H;

  logic          clk = 1'b0;
  logic          reset_n, start, pp_pop;
  logic [DB-1:0] dc_disp, pp_disp;
  logic [7:0]    dc_conf, pp_conf;
  logic          dc_valid, dc_ready, mask_valid, mask_ready, pp_valid;
  logic [D-1:0]  mask_col, pp_pixels;
  logic [1:0]    x_count, y_count;
  logic          busy, frame_done, credit_err;

  always #5 clk = ~clk;

  disp_conf_sequencer #(
    .disp_bits(DB), .dec_factor(D), .out_width(W), .out_height(H), .fifo_depth(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .dc_disp(dc_disp), .dc_conf(dc_conf), .dc_valid(dc_valid), .dc_ready(dc_ready),
    .mask_col(mask_col), .mask_valid(mask_valid), .mask_ready(mask_ready),
    .pp_pixels(pp_pixels), .pp_disp(pp_disp), .pp_conf(pp_conf), .pp_valid(pp_valid),
    .pp_pop(pp_pop), .x_count(x_count), .y_count(y_count),
    .busy(busy), .frame_done(frame_done), .credit_err(credit_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: mode 0 idle, 1 run, 2 drain.
  int m_mode, m_beats, m_cred, m_err, m_disp, m_conf, m_pix, m_pv, m_fd;
  int cyc = 0;
  int pop_q[$];
  int pv_count, fd_count;
  int pop_mode;   // 0 none, 1 echo 3 cycles after a sample's last beat, 2 random
  int valid_pct;
  int start_pct;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    m_mode = 0; m_beats = 0; m_cred = DEPTH; m_err = 0;
    m_disp = 0; m_conf = 0; m_pix = 0; m_pv = 0; m_fd = 0;
    pop_q.delete();
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, " pp_valid"},   pp_valid,   0);
    chk({pfx, " pp_pixels"},  pp_pixels,  0);
    chk({pfx, " pp_disp"},    pp_disp,    0);
    chk({pfx, " pp_conf"},    pp_conf,    0);
    chk({pfx, " dc_ready"},   dc_ready,   0);
    chk({pfx, " mask_ready"}, mask_ready, 0);
    chk({pfx, " x_count"},    x_count,    0);
    chk({pfx, " y_count"},    y_count,    0);
    chk({pfx, " busy"},       busy,       0);
    chk({pfx, " frame_done"}, frame_done, 0);
    chk({pfx, " credit_err"}, credit_err, 0);
  endtask

  // One clock with the inputs currently driven; checks readies before the
  // edge and all registered outputs just after it.
  task automatic tick();
    bit beat0, issue, take, popv;
    int old_cred;
    #1;
    beat0 = (m_beats % D) == 0;
    issue = (m_mode == 1) && mask_valid && (!beat0 || (dc_valid && m_cred > 0));
    take  = issue && beat0;
    popv  = pp_pop;
    chk("mask_ready", mask_ready, issue);
    chk("dc_ready", dc_ready, take);
    old_cred = m_cred;
    m_fd = (m_mode == 2) && (old_cred == DEPTH);
    m_pv = issue;
    if (issue) begin
      m_pix = mask_col;
      if (beat0) begin
        m_disp = dc_disp;
        m_conf = dc_conf;
      end
      m_beats++;
      if (pop_mode == 1 && (m_beats % D) == 0) pop_q.push_back(cyc + 3);
    end
    if (popv && old_cred == DEPTH) m_err = 1;
    m_cred = old_cred - int'(take) + int'(popv);
    if (m_cred > DEPTH) m_cred = DEPTH;
    case (m_mode)
      0: if (start) begin m_mode = 1; m_beats = 0; end
      1: if (m_beats == TOTAL) m_mode = 2;
      2: if (old_cred == DEPTH) m_mode = 0;
      default: m_mode = 0;
    endcase
    @(posedge clk);
    #1;
    cyc++;
    if (take) begin
      dc_disp = DB'($urandom);
      dc_conf = 8'($urandom);
    end
    if (issue) mask_col = D'($urandom);
    chk("pp_valid", pp_valid, m_pv);
    chk("pp_pixels", pp_pixels, m_pix);
    chk("pp_disp", pp_disp, m_disp);
    chk("pp_conf", pp_conf, m_conf);
    chk("x_count", x_count, (m_mode == 0) ? 0 : (m_beats / D) % W);
    chk("y_count", y_count, (m_mode == 0) ? 0 : (m_beats / (D * W)) % H);
    chk("busy", busy, m_mode != 0);
    chk("frame_done", frame_done, m_fd);
    chk("credit_err", credit_err, m_err);
    chk("credits", dut.credits, m_cred);
    if (pp_valid) pv_count++;
    if (frame_done) fd_count++;
  endtask

  task automatic auto_cycle();
    dc_valid   = ($urandom_range(99) < valid_pct);
    mask_valid = ($urandom_range(99) < valid_pct);
    start      = (m_mode != 0) && ($urandom_range(99) < start_pct);
    case (pop_mode)
      1: begin
        pp_pop = (pop_q.size() > 0) && (pop_q[0] == cyc);
        if (pp_pop) void'(pop_q.pop_front());
      end
      2: pp_pop = (m_cred < DEPTH) && ($urandom_range(1) == 1);
      default: pp_pop = 1'b0;
    endcase
    tick();
  endtask

  task automatic start_frame();
    start = 1'b1; dc_valid = 1'b0; mask_valid = 1'b0; pp_pop = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_idle(input string tag, input int budget);
    int n = 0;
    while (m_mode != 0 && n < budget) begin
      auto_cycle();
      n++;
    end
    chk({tag, " frame completes"}, busy, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; pp_pop = 1'b0;
    dc_valid = 1'b0; mask_valid = 1'b0;
    dc_disp = DB'($urandom); dc_conf = 8'($urandom); mask_col = D'($urandom);
    pop_mode = 0; valid_pct = 100; start_pct = 0;
    model_init();
    #12;
    chk_all_zero("reset");
    chk("reset credits", dut.credits, DEPTH);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Frame 1: continuous streams, pops echoed 3 cycles after each sample.
    pop_mode = 1; valid_pct = 100; start_pct = 0;
    start_frame();
    pv_count = 0; fd_count = 0;
    run_to_idle("f1", 200);
    repeat (3) auto_cycle();
    chk("f1 beat count", pv_count, TOTAL);
    chk("f1 frame_done count", fd_count, 1);
    chk("f1 busy after", busy, 0);

    // Frame 2: no pops, credits run out and issue stalls.
    pop_mode = 0; valid_pct = 100; start_pct = 0;
    start_frame();
    pv_count = 0;
    repeat (30) auto_cycle();
    chk("bp beats before stall", pv_count, 2 * DEPTH);
    chk("bp credits", dut.credits, 0);
    chk("bp pp_valid", pp_valid, 0);
    dc_valid = 1'b1; mask_valid = 1'b1; #1;
    chk("bp dc_ready", dc_ready, 0);
    chk("bp mask_ready", mask_ready, 0);
    pv_count = 0;
    pp_pop = 1'b1;
    tick();
    pp_pop = 1'b0;
    repeat (6) tick();
    chk("bp beats after one pop", pv_count, D);
    pop_mode = 2; valid_pct = 70; start_pct = 20;
    run_to_idle("f2", 400);

    // Frame 3: take and pop together at credits 3, then a mid-sample stall.
    pop_mode = 0; valid_pct = 100; start_pct = 0;
    start_frame();
    for (int i = 0; i < 40 && !(m_cred == 3 && (m_beats % D) == 0); i++) auto_cycle();
    chk("tp credits before", dut.credits, 3);
    dc_valid = 1'b1; mask_valid = 1'b1; pp_pop = 1'b1;
    tick();
    pp_pop = 1'b0;
    chk("tp credits after", dut.credits, 3);
    mask_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall pp_valid", pp_valid, 0);
      chk("stall pp_disp", pp_disp, m_disp);
    end
    mask_valid = 1'b1;
    tick();
    chk("resume pp_valid", pp_valid, 1);
    chk("resume pp_conf", pp_conf, m_conf);
    pop_mode = 2; valid_pct = 60; start_pct = 20;
    run_to_idle("f3", 400);

    // Pop while idle with all credits home.
    dc_valid = 1'b0; mask_valid = 1'b0; pp_pop = 1'b1;
    tick();
    pp_pop = 1'b0;
    chk("idle pop credit_err", credit_err, 1);
    chk("idle pop credits", dut.credits, DEPTH);
    tick();

    // Frame 4: random traffic, abandoned by reset mid-frame.
    pop_mode = 2; valid_pct = 80; start_pct = 20;
    start_frame();
    repeat (15) auto_cycle();
    dc_valid = 1'b1; mask_valid = 1'b1; pp_pop = 1'b0; start = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_init();
    chk("post reset credits", dut.credits, DEPTH);
    chk("post reset credit_err", credit_err, 0);
    dc_valid = 1'b0; mask_valid = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
